// File: rtl/keypad_emulator_if.sv
// Keypad emulator bundle: request handshake, column strobes in, row sense out, status.
// master = scanner/requester side, slave = emulated keypad.
interface keypad_emulator_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] col;
    logic [3:0] row;
    logic       busy;
    logic       done;

    modport master (
        output key_valid, key_code, col,
        input  key_ready, row, busy, done
    );

    modport slave (
        input  key_valid, key_code, col,
        output key_ready, row, busy, done
    );
endinterface

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad responder: presses a requested key for HOLD_CYCLES, then stays open for GAP_CYCLES.
// Optional contact bounce at press and release is built when KEYPAD_BOUNCE_EN is defined.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 1000,
`ifdef KEYPAD_BOUNCE_EN
    parameter int BOUNCE_CYCLES = 64,
    parameter int BOUNCE_STEP   = 8,
`endif
    parameter int CW            = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    keypad_emulator_if.slave   kp
);

    // A zero length is treated as a single cycle.
    localparam logic [CW-1:0] HOLD_LAST = (HOLD_CYCLES == 0) ? '0 : CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES  == 0) ? '0 : CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [3:0]      code_q,  code_d;
    logic            done_q,  done_d;
    logic            contact;
    logic [3:0]      row;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= 4'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        code_d  = code_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (kp.key_valid) begin
                    state_d = S_PRESS;
                    code_d  = kp.key_code;
                end
            end
            S_PRESS: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef KEYPAD_BOUNCE_EN
    logic [CW-1:0] bphase;
    logic          in_bounce;

    // Contact starts closed in each window and flips every BOUNCE_STEP cycles.
    always_comb begin
        bphase    = cnt_q / CW'(BOUNCE_STEP);
        in_bounce = (cnt_q < CW'(BOUNCE_CYCLES));
        contact   = 1'b0;
        case (state_q)
            S_PRESS: contact = in_bounce ? ~bphase[0] : 1'b1;
            S_GAP:   contact = in_bounce ? ~bphase[0] : 1'b0;
            default: contact = 1'b0;
        endcase
    end
`else
    assign contact = (state_q == S_PRESS);
`endif

    // Combinational path from col to row so the scanner sees the key in the strobe cycle.
    always_comb begin
        row = 4'b1111;
        if (contact && !kp.col[code_q[1:0]])
            row[code_q[3:2]] = 1'b0;
    end

    assign kp.row       = row;
    assign kp.key_ready = (state_q == S_IDLE);
    assign kp.busy      = (state_q != S_IDLE);
    assign kp.done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator; with KEYPAD_BOUNCE_EN defined it runs the bounce scenario instead
// of the clean-contact timing scenarios.
module tb_keypad_emulator;

`ifdef KEYPAD_BOUNCE_EN
    localparam int HOLD = 40;
    localparam int GAP  = 20;
`else
    localparam int HOLD = 20;
    localparam int GAP  = 10;
`endif

    logic clock;
    logic reset_n;
    int   vectors;
    int   miscompares;

    keypad_emulator_if kp();

`ifdef KEYPAD_BOUNCE_EN
    keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .BOUNCE_CYCLES(16),
                      .BOUNCE_STEP(4), .CW(16)) dut (
        .clock(clock), .reset_n(reset_n), .kp(kp));
`else
    keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CW(16)) dut (
        .clock(clock), .reset_n(reset_n), .kp(kp));
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request at a falling edge; it transfers on the following rising edge.
    task automatic start_press(input logic [3:0] code, input logic [3:0] c);
        @(negedge clock);
        kp.key_valid = 1'b1;
        kp.key_code  = code;
        kp.col       = c;
        @(posedge clock);
        #1;
        kp.key_valid = 1'b0;
        kp.key_code  = 4'h9;
    endtask

    task automatic test_reset;
        reset_n      = 1'b0;
        kp.key_valid = 1'b0;
        kp.key_code  = 4'h0;
        kp.col       = 4'b0000;
        #12;
        vectors++; if (kp.row !== 4'b1111) begin miscompares++; $display("FAIL reset_row got=%b want=1111", kp.row); end
        vectors++; if (kp.key_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b want=1", kp.key_ready); end
        vectors++; if (kp.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", kp.busy); end
        vectors++; if (kp.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", kp.done); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            vectors++;
            if (kp.row !== 4'b1111 || kp.key_ready !== 1'b1 || kp.busy !== 1'b0 || kp.done !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle got row=%b rdy=%b busy=%b done=%b want 1111/1/0/0",
                         kp.row, kp.key_ready, kp.busy, kp.done);
            end
        end
    endtask

    // Code 6 = row 1, column 2: responds to col[2]=0 by pulling row[1] low.
    task automatic test_press_timing;
        start_press(4'h6, 4'b1011);
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clock);
            vectors++; if (kp.row !== 4'b1101) begin miscompares++; $display("FAIL press_row cyc=%0d got=%b want=1101", i, kp.row); end
            vectors++; if (kp.busy !== 1'b1 || kp.key_ready !== 1'b0 || kp.done !== 1'b0) begin
                miscompares++; $display("FAIL press_status cyc=%0d got busy=%b rdy=%b done=%b want 1/0/0", i, kp.busy, kp.key_ready, kp.done); end
            kp.col = 4'b1101;
            #1;
            vectors++; if (kp.row !== 4'b1111) begin miscompares++; $display("FAIL press_other_col cyc=%0d got=%b want=1111", i, kp.row); end
            kp.col = 4'b1111;
            #1;
            vectors++; if (kp.row !== 4'b1111) begin miscompares++; $display("FAIL press_no_strobe cyc=%0d got=%b want=1111", i, kp.row); end
            kp.col = 4'b1011;
        end
        for (int i = 0; i < GAP; i++) begin
            @(negedge clock);
            vectors++; if (kp.row !== 4'b1111 || kp.busy !== 1'b1 || kp.done !== 1'b0) begin
                miscompares++; $display("FAIL gap cyc=%0d got row=%b busy=%b done=%b want 1111/1/0", i, kp.row, kp.busy, kp.done); end
        end
        @(negedge clock);
        vectors++; if (kp.done !== 1'b1 || kp.busy !== 1'b0 || kp.key_ready !== 1'b1) begin
            miscompares++; $display("FAIL done_pulse got done=%b busy=%b rdy=%b want 1/0/1", kp.done, kp.busy, kp.key_ready); end
        @(negedge clock);
        vectors++; if (kp.done !== 1'b0) begin miscompares++; $display("FAIL done_width got=%b want=0", kp.done); end
    endtask

    task automatic test_back_to_back;
        int  idx;
        bit  seen;
        @(negedge clock);
        kp.key_valid = 1'b1;
        kp.key_code  = 4'hF;
        kp.col       = 4'b0111;
        @(posedge clock);
        #1;
        kp.key_code  = 4'h0;
        seen = 1'b0;
        idx  = -1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clock);
            if (k == 0) begin
                vectors++; if (kp.row !== 4'b0111) begin miscompares++; $display("FAIL b2b_F_row got=%b want=0111", kp.row); end
                kp.col = 4'b1110;
                #1;
                vectors++; if (kp.row !== 4'b1111) begin miscompares++; $display("FAIL b2b_F_col0 got=%b want=1111", kp.row); end
                kp.col = 4'b0111;
            end
            if (kp.done === 1'b1) begin
                seen = 1'b1;
                idx  = k;
            end
        end
        vectors++; if (idx !== HOLD + GAP) begin miscompares++; $display("FAIL b2b_first_done cyc got=%0d want=%0d", idx, HOLD + GAP); end
        vectors++; if (kp.key_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_on_done got=%b want=1", kp.key_ready); end
        @(posedge clock);
        #1;
        kp.key_valid = 1'b0;
        kp.key_code  = 4'hA;
        seen = 1'b0;
        idx  = -1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clock);
            if (k == 0) begin
                vectors++; if (kp.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_busy got=%b want=1", kp.busy); end
                kp.col = 4'b1110;
                #1;
                vectors++; if (kp.row !== 4'b1110) begin miscompares++; $display("FAIL b2b_0_row got=%b want=1110", kp.row); end
                kp.col = 4'b0111;
                #1;
                vectors++; if (kp.row !== 4'b1111) begin miscompares++; $display("FAIL b2b_0_col3 got=%b want=1111", kp.row); end
            end
            if (kp.done === 1'b1) begin
                seen = 1'b1;
                idx  = k;
            end
        end
        vectors++; if (idx !== HOLD + GAP) begin miscompares++; $display("FAIL b2b_second_done cyc got=%0d want=%0d", idx, HOLD + GAP); end
        kp.col = 4'b1011;
    endtask

    task automatic test_reset_mid_press;
        int dones;
        start_press(4'h6, 4'b1011);
        repeat (5) @(negedge clock);
        vectors++; if (kp.row !== 4'b1101) begin miscompares++; $display("FAIL midrst_pre_row got=%b want=1101", kp.row); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if (kp.row !== 4'b1111) begin miscompares++; $display("FAIL midrst_row got=%b want=1111", kp.row); end
        vectors++; if (kp.busy !== 1'b0 || kp.key_ready !== 1'b1 || kp.done !== 1'b0) begin
            miscompares++; $display("FAIL midrst_status got busy=%b rdy=%b done=%b want 0/1/0", kp.busy, kp.key_ready, kp.done); end
        @(negedge clock);
        reset_n = 1'b1;
        dones = 0;
        for (int k = 0; k < HOLD + GAP + 10; k++) begin
            @(negedge clock);
            if (kp.done === 1'b1) dones++;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
        vectors++; if (kp.key_ready !== 1'b1 || kp.row !== 4'b1111) begin
            miscompares++; $display("FAIL midrst_idle got rdy=%b row=%b want 1/1111", kp.key_ready, kp.row); end
    endtask

    task automatic test_ignore_valid;
        int dones;
        int idx;
        start_press(4'h6, 4'b1011);
        @(negedge clock);
        @(negedge clock);
        kp.key_valid = 1'b1;
        kp.key_code  = 4'h3;
        @(posedge clock);
        #1;
        kp.key_valid = 1'b0;
        dones = 0;
        idx   = -1;
        for (int k = 2; k < HOLD + GAP + 20; k++) begin
            @(negedge clock);
            if (k == 5) begin
                vectors++; if (kp.row !== 4'b1101) begin miscompares++; $display("FAIL ignore_row got=%b want=1101", kp.row); end
                kp.col = 4'b0111;
                #1;
                vectors++; if (kp.row !== 4'b1111) begin miscompares++; $display("FAIL ignore_code3 got=%b want=1111", kp.row); end
                kp.col = 4'b1011;
            end
            if (kp.done === 1'b1) begin
                dones++;
                if (idx < 0) idx = k;
            end
        end
        vectors++; if (dones !== 1) begin miscompares++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        vectors++; if (idx !== HOLD + GAP) begin miscompares++; $display("FAIL ignore_done_cyc got=%0d want=%0d", idx, HOLD + GAP); end
        vectors++; if (kp.busy !== 1'b0) begin miscompares++; $display("FAIL ignore_no_requeue got busy=%b want=0", kp.busy); end
    endtask

`ifdef KEYPAD_BOUNCE_EN
    // Bounce window 16, step 4: closed 0-3, open 4-7, closed 8-11, open 12-15 of each window.
    task automatic test_bounce;
        logic [3:0] want;
        bit         closed;
        int         j;
        start_press(4'h6, 4'b1011);
        for (int k = 0; k < HOLD + GAP; k++) begin
            @(negedge clock);
            if (k < HOLD) begin
                closed = (k < 16) ? (((k / 4) % 2) == 0) : 1'b1;
            end else begin
                j = k - HOLD;
                closed = (j < 16) ? (((j / 4) % 2) == 0) : 1'b0;
            end
            want = closed ? 4'b1101 : 4'b1111;
            vectors++; if (kp.row !== want) begin miscompares++; $display("FAIL bounce_row cyc=%0d got=%b want=%b", k, kp.row, want); end
        end
        @(negedge clock);
        vectors++; if (kp.done !== 1'b1) begin miscompares++; $display("FAIL bounce_done got=%b want=1", kp.done); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
`ifdef KEYPAD_BOUNCE_EN
        test_bounce();
        test_back_to_back();
`else
        test_press_timing();
        test_back_to_back();
        test_reset_mid_press();
        test_ignore_valid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
